gcn_transform_ctrl: RTL

//  Sequencer for the GCN feature transformation FM(FEATURE_ROWS x FEATURE_COLS) x W(FEATURE_COLS x WEIGHT_COLS).

---
 rtl/gcn_ctrl_pkg.sv | 33 +++
 rtl/gcn_transform_ctrl_counter.sv | 38 +++
 rtl/gcn_transform_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gcn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcn_ctrl_pkg
// Description : Shared types, default dimensions and index-width helper for
//               the GCN feature-transform sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gcn_ctrl_pkg;

  // Sequencer states: wait for start, issue reads, flush the pipe, report.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Default problem size: 6 nodes, 96-long features, 3 output features.
  localparam int DEF_FEATURE_ROWS = 6;
  localparam int DEF_FEATURE_COLS = 96;
  localparam int DEF_WEIGHT_COLS  = 3;

  // Cycles spent flushing the MAC stage and the output stage.
  localparam int DRAIN_CYCLES = 2;

  // Index width for a dimension of n entries; a 1-entry dimension still gets
  // a 1-bit index so no port or register collapses to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcn_transform_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : gcn_index_counter
// Description : Modulo-MAX index counter with synchronous clear and a wrap
//               strobe, chained to build the nested row/elem/wcol loops.
// Revision    : 1.0 - initial release
// ============================================================================
module gcn_index_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] C_LAST = W'(MAX - 1);

  // Wrap fires on the advance that takes the count from MAX-1 back to 0,
  // which is exactly the enable of the next-outer loop counter.
  assign wrap = enable && (count == C_LAST);

  // Count advances on enable, returns to 0 on wrap or on an explicit clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcn_transform_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gcn_transform_ctrl
// Description : Sequencer for FM(FEATURE_ROWS x FEATURE_COLS) x
//               W(FEATURE_COLS x WEIGHT_COLS). Issues one FM/W read per cycle
//               in wcol-outer / row-middle / elem-inner order, drives MAC
//               load/accumulate/last strobes one cycle later and an
//               output-buffer write one cycle after each dot product's last
//               element.
// Config      : GCN_CTRL_STALL_EN - adds the mem_ready input; reads are held
//               (indices frozen, bubble in the pipe) while mem_ready is low.
//               Undefined: no mem_ready port, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module gcn_transform_ctrl
  import gcn_ctrl_pkg::*;
#(
  parameter int FEATURE_ROWS = DEF_FEATURE_ROWS,
  parameter int FEATURE_COLS = DEF_FEATURE_COLS,
  parameter int WEIGHT_COLS  = DEF_WEIGHT_COLS,
  parameter int ROW_W        = idx_w(FEATURE_ROWS),
  parameter int ELEM_W       = idx_w(FEATURE_COLS),
  parameter int WCOL_W       = idx_w(WEIGHT_COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
`ifdef GCN_CTRL_STALL_EN
  input  logic              mem_ready,
`endif
  output logic              busy,
  output logic              done,
  output logic              read_en,
  output logic [ROW_W-1:0]  row_idx,
  output logic [ELEM_W-1:0] elem_idx,
  output logic [WCOL_W-1:0] wcol_idx,
  output logic              mac_valid,
  output logic              mac_clear,
  output logic              mac_last,
  output logic              out_wr_en,
  output logic [ROW_W-1:0]  out_row,
  output logic [WCOL_W-1:0] out_col
);

  localparam logic [ELEM_W-1:0] C_ELEM_LAST  = ELEM_W'(FEATURE_COLS - 1);
  localparam logic [0:0]        C_DRAIN_LAST = 1'(DRAIN_CYCLES - 1);

  ctrl_state_e       state;
  logic [0:0]        drain_cnt;
  logic              read_ok;
  logic              run_start;
  logic              elem_wrap;
  logic              row_wrap;
  logic              wcol_wrap;
  logic [ROW_W-1:0]  mac_row;
  logic [WCOL_W-1:0] mac_col;

`ifdef GCN_CTRL_STALL_EN
  assign read_ok = mem_ready;
`else
  assign read_ok = 1'b1;
`endif

  // A read is issued every RUN cycle the memories can take it; a stalled
  // cycle simply issues nothing, so the counters hold and the pipe bubbles.
  assign read_en   = (state == RUN) && read_ok;
  assign run_start = (state == IDLE) && start;

  // Loop nest: elem innermost, row middle, wcol outermost (weight column
  // stays resident while every row sweeps through it).
  gcn_index_counter #(.MAX(FEATURE_COLS), .W(ELEM_W)) u_elem_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (run_start),
    .enable  (read_en),
    .count   (elem_idx),
    .wrap    (elem_wrap)
  );

  gcn_index_counter #(.MAX(FEATURE_ROWS), .W(ROW_W)) u_row_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (run_start),
    .enable  (elem_wrap),
    .count   (row_idx),
    .wrap    (row_wrap)
  );

  gcn_index_counter #(.MAX(WEIGHT_COLS), .W(WCOL_W)) u_wcol_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (run_start),
    .enable  (row_wrap),
    .count   (wcol_idx),
    .wrap    (wcol_wrap)
  );

  // Control FSM: the final wrap of the outermost counter marks the last read;
  // DRAIN then lets the MAC and output stages empty before done pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (wcol_wrap) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == C_DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // MAC stage: read data lands one cycle after the read; the first element
  // loads the accumulator and the last one closes the dot product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_valid <= 1'b0;
      mac_clear <= 1'b0;
      mac_last  <= 1'b0;
      mac_row   <= '0;
      mac_col   <= '0;
    end else begin
      mac_valid <= read_en;
      mac_clear <= read_en && (elem_idx == '0);
      mac_last  <= read_en && (elem_idx == C_ELEM_LAST);
      if (read_en) begin
        mac_row <= row_idx;
        mac_col <= wcol_idx;
      end
    end
  end

  // Output stage: the finished sum is written one cycle after its last MAC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr_en <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      out_wr_en <= mac_valid && mac_last;
      if (mac_valid && mac_last) begin
        out_row <= mac_row;
        out_col <= mac_col;
      end
    end
  end

endmodule
`default_nettype wire
